serial_add_sub: RTL and testbench

Bit-serial two's-complement adder/subtractor that computes `a ± b` one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. It is the sequential, area-minimal counterpart of the 4-bit ripple-carry adder and adds the subtract direction. An operation starts on a one-cycle request, runs for WIDTH cycles and ends with a one-cycle `done` pulse. Results are held until the next operation completes.

---
 rtl/serial_add_sub_pkg.sv | 18 +
 rtl/serial_add_sub_full_adder.sv | 13 +
 rtl/serial_add_sub.sv | 100 ++++++++++
 tb/tb_serial_add_sub.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Bit-counter width: enough to count 0..width-1, never narrower than 1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder used as the serial bit cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement add/subtract, one bit per clock, LSB first.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_sr, b_sr;
    logic [WIDTH-2:0]   r_sr;      // bits already produced; the MSB arrives last
    logic [WIDTH-1:0]   r_cat;
    logic               carry;
    logic               sum_bit, cout_bit;
    logic               accept, last;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST);
    assign r_cat  = {sum_bit, r_sr};
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (sum_bit),
        .cout (cout_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; RUN ignores start, DONE can chain straight into RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/result shift registers, carry flop and bit counter.
    // Subtract is a + ~b + 1: invert b on load and seed the carry with mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= (mode == MODE_SUB) ? ~b : b;
            carry <= mode;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= r_cat[WIDTH-1:1];
            carry <= cout_bit;
            cnt   <= cnt + 1'b1;
        end
    end

    // Output registers update only on the final bit, so they hold through
    // IDLE and the next RUN. Carry into the MSB is the flop value this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (last) begin
            result    <= r_cat;
            carry_out <= cout_bit;
            overflow  <= carry ^ cout_bit;
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed plan plus random ops
// against an arithmetic reference model.
module tb_serial_add_sub;
    import serial_add_sub_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, start, mode;
    logic [W-1:0] a, b, result;
    logic         busy, done, carry_out, overflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_r;
    logic         exp_c, exp_v;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
    function automatic void model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c, output logic v);
        int ux, uy, sx, sy, s, sv;
        ux = int'(x);
        uy = int'(y);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        if (m == MODE_ADD) begin
            s  = ux + uy;
            c  = (s >= (1 << W));
            sv = sx + sy;
        end else begin
            s  = ux - uy;
            c  = (ux >= uy);
            sv = sx - sy;
        end
        r = W'(s);
        v = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
    endfunction

    task automatic chk_outs(input string tag);
        chk({tag, ".result"}, result, exp_r);
        chk({tag, ".cout"}, carry_out, exp_c);
        chk({tag, ".ovf"}, overflow, exp_v);
    endtask

    // Called at a negedge with the DUT in IDLE or DONE. Returns at the
    // negedge of the DONE cycle with start low. A spurious start with
    // garbage operands is pulsed during RUN and must be ignored.
    task automatic op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] gx, input logic [W-1:0] gy, input string tag);
        logic [W-1:0] r;
        logic         c, v;
        start = 1'b1; mode = m; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~m; a = gx; b = gy;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".run_done"}, done, 0);
            chk({tag, ".held"}, result, exp_r);
            start = (k == 1);
        end
        @(negedge clk);
        start = 1'b0;
        model(m, x, y, r, c, v);
        exp_r = r; exp_c = c; exp_v = v;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy_low"}, busy, 0);
        chk_outs(tag);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, ".idle_done"}, done, 0);
        chk({tag, ".idle_busy"}, busy, 0);
        chk_outs({tag, ".idle"});
    endtask

    initial begin
        logic [W-1:0] rx, ry, gx, gy;
        logic         rm;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        exp_r = '0; exp_c = 1'b0; exp_v = 1'b0;
        #1;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk_outs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_chk("post_reset");

        // Directed plan, with plan constants checked directly as well.
        op(MODE_ADD, 4'd3, 4'd2, 4'd9, 4'd9, "p1");
        chk("p1.plan", {result, carry_out, overflow}, {4'd5, 1'b0, 1'b0});
        idle_chk("p1");
        op(MODE_ADD, 4'd10, 4'd8, 4'd1, 4'd1, "p2");
        chk("p2.plan", {result, carry_out, overflow}, {4'd2, 1'b1, 1'b1});
        idle_chk("p2");
        op(MODE_SUB, 4'd8, 4'd1, 4'd3, 4'd3, "p3");
        chk("p3.plan", {result, carry_out, overflow}, {4'd7, 1'b1, 1'b1});
        idle_chk("p3");
        op(MODE_SUB, 4'd2, 4'd3, 4'd0, 4'd0, "p4");
        chk("p4.plan", {result, carry_out, overflow}, {4'd15, 1'b0, 1'b0});
        idle_chk("p4");

        // Ignored start during RUN, then a start accepted in the DONE cycle.
        op(MODE_ADD, 4'd1, 4'd1, 4'd7, 4'd7, "p5a");
        chk("p5a.plan", result, 4'd2);
        op(MODE_SUB, 4'd5, 4'd4, 4'd7, 4'd7, "p5b");
        chk("p5b.plan", result, 4'd1);
        idle_chk("p5");

        // Reset in the second RUN cycle aborts at once with no done.
        start = 1'b1; mode = MODE_ADD; a = 4'd9; b = 4'd9;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        exp_r = '0; exp_c = 1'b0; exp_v = 1'b0;
        chk("p6.rst_busy", busy, 0);
        chk("p6.rst_done", done, 0);
        chk_outs("p6.rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("p6.no_done", done, 0);
        end
        rst = 1'b0;
        op(MODE_ADD, 4'd6, 4'd7, 4'd2, 4'd2, "p6");
        chk("p6.plan", {result, carry_out, overflow}, {4'd13, 1'b0, 1'b1});
        idle_chk("p6");

        // Random operations, mixing back-to-back and idle gaps.
        for (int i = 0; i < 40; i++) begin
            rm = 1'($urandom_range(0, 1));
            rx = W'($urandom);
            ry = W'($urandom);
            gx = W'($urandom);
            gy = W'($urandom);
            op(rm, rx, ry, gx, gy, "rand");
            if ($urandom_range(0, 1) == 1) idle_chk("rand");
        end
        idle_chk("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
